spi_xfer_ctrl: RTL and testbench

//  Single-clock SPI master sequencer for the SPI peripherals on the perip bus, e.g. the bit-reversal device.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_clkgen.sv | 45 ++++
 rtl/spi_xfer_ctrl.sv | 143 ++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state type and parameter range checks for the SPI transfer sequencer
// Purpose: state encoding used by spi_xfer_ctrl and a helper that validates its parameters.
// Contents: state_t (IDLE, SETUP, SHIFT, GAP, DONE), legal ranges, params_ok().
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int LEN_MIN = 2;
  localparam int LEN_MAX = 64;
  localparam int NSS_MAX = 8;

  function automatic bit params_ok(int div, int len, int nss, int gap);
    return (div >= 1) && (len >= LEN_MIN) && (len <= LEN_MAX) &&
           (nss >= 1) && (nss <= NSS_MAX) && (gap >= 1);
  endfunction

endpackage

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - sck divider with one-cycle edge strobes
// Purpose: divides clock into a mode-0 sck while enabled; idles low with a cleared divider otherwise.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high
//   en     in   run the divider (high only while shifting)
//   sck    out  SPI clock, low when disabled
//   rise   out  high in the cycle whose closing edge drives sck 0->1
//   fall   out  high in the cycle whose closing edge drives sck 1->0
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;

  // Strobes are combinational so the owner acts on the same edge that moves sck.
  assign wrap = en && (div_cnt == CW'(DIV - 1));
  assign rise = wrap && !sck;
  assign fall = wrap && sck;

  always_ff @(posedge clock) begin
    if (reset || !en) begin
      div_cnt <= '0;
      sck     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sck     <= !sck;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// rtl/spi_xfer_ctrl.sv - single-transfer SPI master sequencer (mode 0, MSB first)
// Purpose: accepts one LEN-bit request, selects the slave(s), clocks the word out on mosi while
//          assembling miso, then holds the response until consumed.
// Ports:
//   clock, reset            system clock; synchronous active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_wdata [LEN]         word to send, MSB first
//   req_ss    [NSS]         one-hot (or multi-hot) slave mask, sampled at accept
//   resp_valid/resp_ready   response handshake, rdata held while valid
//   resp_rdata [LEN]        received word, first bit in [LEN-1]
//   busy                    accept until response consumed
//   spi_sck, spi_ss, spi_mosi, spi_miso   external SPI pins (ss active low)
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DIV = 4,
  parameter int LEN = 16,
  parameter int NSS = 2,
  parameter int GAP = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [LEN-1:0] req_wdata,
  input  logic [NSS-1:0] req_ss,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [LEN-1:0] resp_rdata,
  output logic           busy,
  output logic           spi_sck,
  output logic [NSS-1:0] spi_ss,
  output logic           spi_mosi,
  input  logic           spi_miso
);

  if (!params_ok(DIV, LEN, NSS, GAP)) begin : g_param_err
    $error("spi_xfer_ctrl: parameter out of range");
  end

  localparam int BW = $clog2(LEN + 1);
  localparam int WW = $clog2(((DIV > GAP) ? DIV : GAP) + 1);

  state_t         state, state_n;
  logic [LEN-1:0] tx, rx;
  logic [NSS-1:0] ss_q;
  logic [BW-1:0]  bit_cnt;
  logic [WW-1:0]  wait_cnt;
  logic           sck_fall;
  logic           rise_unused;
  logic           setup_last, gap_last, bit_last;

  // Rising sck edges need no master action: the slave samples mosi, which is already stable.
  spi_clkgen #(.DIV(DIV)) u_clkgen (
    .clock (clock),
    .reset (reset),
    .en    (state == ST_SHIFT),
    .sck   (spi_sck),
    .rise  (rise_unused),
    .fall  (sck_fall)
  );

  assign setup_last = (wait_cnt == WW'(DIV - 1));
  assign gap_last   = (wait_cnt == WW'(GAP - 1));
  assign bit_last   = (bit_cnt == BW'(LEN - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    spi_ss     = '1;
    spi_mosi   = 1'b1;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_n = ST_SETUP;
      end
      ST_SETUP: begin
        spi_ss   = ~ss_q;
        spi_mosi = tx[LEN-1];
        if (setup_last) state_n = ST_SHIFT;
      end
      ST_SHIFT: begin
        spi_ss   = ~ss_q;
        spi_mosi = tx[LEN-1];
        if (sck_fall && bit_last) state_n = ST_GAP;
      end
      ST_GAP: begin
        if (gap_last) state_n = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // wait_cnt times both SETUP and GAP; SETUP leaves it cleared so GAP starts from zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx         <= '0;
      rx         <= '0;
      ss_q       <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      resp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            tx       <= req_wdata;
            ss_q     <= req_ss;
            rx       <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
          end
        end
        ST_SETUP: wait_cnt <= setup_last ? '0 : wait_cnt + WW'(1);
        ST_SHIFT: begin
          if (sck_fall) begin
            rx      <= {rx[LEN-2:0], spi_miso};
            tx      <= {tx[LEN-2:0], 1'b0};
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        ST_GAP: begin
          wait_cnt <= gap_last ? '0 : wait_cnt + WW'(1);
          if (gap_last) resp_rdata <= rx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb/tb_spi_xfer_ctrl.sv - directed self-checking bench for spi_xfer_ctrl with a bit-reversal slave
module tb_spi_xfer_ctrl;

  localparam int DIV = 4;
  localparam int LEN = 16;
  localparam int NSS = 2;
  localparam int GAP = 2;
  localparam int XFER_LAT = 1 + DIV + 2 * DIV * LEN + GAP;

  logic           clock = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [LEN-1:0] req_wdata;
  logic [NSS-1:0] req_ss;
  logic           resp_valid;
  logic           resp_ready;
  logic [LEN-1:0] resp_rdata;
  logic           busy;
  logic           spi_sck;
  logic [NSS-1:0] spi_ss;
  logic           spi_mosi;
  logic           spi_miso;

  int n_cmp = 0;
  int n_err = 0;

  spi_xfer_ctrl #(.DIV(DIV), .LEN(LEN), .NSS(NSS), .GAP(GAP)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wdata  (req_wdata),
    .req_ss     (req_ss),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .busy       (busy),
    .spi_sck    (spi_sck),
    .spi_ss     (spi_ss),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso)
  );

  always #5 clock = ~clock;

  // Slave on ss[0]: captures the first byte MSB-first, answers 1s meanwhile, then returns the
  // bit-reversed byte LSB-first (so the master sees the original byte in its low half).
  logic [7:0] sl_rx = 8'h00;
  logic [7:0] sl_rev = 8'h00;
  logic       sl_miso = 1'b1;
  int         sl_bit = 0;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) bitrev8[i] = v[7-i];
  endfunction

  always @(negedge spi_ss[0]) begin
    sl_bit  = 0;
    sl_miso = 1'b1;
  end
  always @(posedge spi_sck) if (!spi_ss[0] && sl_bit < 8) sl_rx = {sl_rx[6:0], spi_mosi};
  always @(negedge spi_sck) begin
    if (!spi_ss[0]) begin
      sl_bit = sl_bit + 1;
      if (sl_bit == 8) sl_rev = bitrev8(sl_rx);
      sl_miso = (sl_bit >= 8 && sl_bit < 16) ? sl_rev[sl_bit-8] : 1'b1;
    end
  end
  assign spi_miso = spi_ss[0] ? 1'b1 : sl_miso;

  int   sck_rises = 0;
  int   ss0_run = 0;
  int   ss0_last_run = 0;
  logic ss0_low_seen = 1'b0;

  always @(posedge spi_sck) sck_rises = sck_rises + 1;
  always @(negedge clock) begin
    if (spi_ss[0]) ss0_run = ss0_run + 1;
    else begin
      if (ss0_run > 0) ss0_last_run = ss0_run;
      ss0_run = 0;
      ss0_low_seen = 1'b1;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one request in an IDLE cycle; returns one cycle after the accepting edge.
  // Inputs are scrambled afterwards to show they are not re-sampled.
  task automatic start(input logic [LEN-1:0] wdata, input logic [NSS-1:0] ss);
    req_valid = 1'b1;
    req_wdata = wdata;
    req_ss    = ss;
    sck_rises = 0;
    step();
    req_valid = 1'b0;
    req_wdata = ~wdata;
    req_ss    = ~ss;
  endtask

  task automatic wait_resp(output int lat, output logic [NSS-1:0] mid_ss);
    lat    = 1;
    mid_ss = '1;
    while (!resp_valid && lat < 2000) begin
      if (lat == 10) mid_ss = spi_ss;
      step();
      lat++;
    end
    chk("resp_valid_seen", {63'd0, resp_valid}, 64'd1);
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  int             lat;
  logic [NSS-1:0] mid_ss;
  logic [LEN-1:0] held;

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_wdata  = '0;
    req_ss     = '0;
    resp_ready = 1'b0;
    step(3);
    reset = 1'b0;

    // 1. idle after reset
    step(20);
    chk("idle_sck", {63'd0, spi_sck}, 64'd0);
    chk("idle_ss", {62'd0, spi_ss}, 64'h3);
    chk("idle_mosi", {63'd0, spi_mosi}, 64'd1);
    chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
    chk("idle_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    chk("idle_rdata", {48'd0, resp_rdata}, 64'd0);

    // 2. A500 to the bit-reversal slave
    start(16'hA500, 2'b01);
    chk("t2_busy", {63'd0, busy}, 64'd1);
    chk("t2_ss_setup", {62'd0, spi_ss}, 64'h2);
    chk("t2_mosi_msb", {63'd0, spi_mosi}, 64'd1);
    wait_resp(lat, mid_ss);
    chk("t2_latency", 64'(lat), 64'(XFER_LAT));
    chk("t2_sck_rises", 64'(sck_rises), 64'd16);
    chk("t2_mid_ss", {62'd0, mid_ss}, 64'h2);
    chk("t2_rdata", {48'd0, resp_rdata}, 64'hFFA5);

    // 3. response held while resp_ready low; accept only after consumption
    held = resp_rdata;
    step(10);
    chk("t3_rdata_held", {48'd0, resp_rdata}, {48'd0, 16'hFFA5});
    chk("t3_valid_held", {63'd0, resp_valid}, 64'd1);
    chk("t3_req_ready_low", {63'd0, req_ready}, 64'd0);
    chk("t3_busy_held", {63'd0, busy}, 64'd1);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_wdata  = 16'h3C00;
    req_ss     = 2'b01;
    step();
    resp_ready = 1'b0;
    chk("t3_not_accepted_ready", {63'd0, req_ready}, 64'd1);
    chk("t3_not_accepted_busy", {63'd0, busy}, 64'd0);
    chk("t3_rdata_after_consume", {48'd0, resp_rdata}, {48'd0, held});
    sck_rises = 0;
    step();
    req_valid = 1'b0;
    chk("t3_accepted_busy", {63'd0, busy}, 64'd1);
    chk("t3_accepted_ready", {63'd0, req_ready}, 64'd0);

    // 4. back-to-back 3C00 then 0100
    wait_resp(lat, mid_ss);
    chk("t4a_latency", 64'(lat), 64'(XFER_LAT));
    chk("t4a_rdata", {48'd0, resp_rdata}, 64'hFF3C);
    consume();
    start(16'h0100, 2'b01);
    chk("t4_gap_ok", {63'd0, ss0_last_run >= GAP}, 64'd1);
    wait_resp(lat, mid_ss);
    chk("t4b_rdata", {48'd0, resp_rdata}, 64'hFF01);
    consume();

    // 5. reset in SHIFT bit 5 while sck is high, then a clean transfer
    start(16'h0000, 2'b01);
    step(49);
    chk("t5_pre_ss", {62'd0, spi_ss}, 64'h2);
    chk("t5_pre_sck", {63'd0, spi_sck}, 64'd1);
    chk("t5_pre_mosi", {63'd0, spi_mosi}, 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rst_ss", {62'd0, spi_ss}, 64'h3);
    chk("t5_rst_sck", {63'd0, spi_sck}, 64'd0);
    chk("t5_rst_mosi", {63'd0, spi_mosi}, 64'd1);
    chk("t5_rst_ready", {63'd0, req_ready}, 64'd1);
    chk("t5_rst_busy", {63'd0, busy}, 64'd0);
    chk("t5_rst_rdata", {48'd0, resp_rdata}, 64'd0);
    step(2);
    start(16'h5A00, 2'b01);
    wait_resp(lat, mid_ss);
    chk("t5_rdata", {48'd0, resp_rdata}, 64'hFF5A);
    consume();

    // 6. slave 1 (absent), miso pulled high; ss[0] must never drop
    step(2);
    ss0_low_seen = 1'b0;
    start(16'h1234, 2'b10);
    wait_resp(lat, mid_ss);
    chk("t6_rdata", {48'd0, resp_rdata}, 64'hFFFF);
    chk("t6_mid_ss", {62'd0, mid_ss}, 64'h1);
    chk("t6_ss0_untouched", {63'd0, ss0_low_seen}, 64'd0);
    consume();

    // multi-hot select drives both lines; slave 0 still answers
    start(16'h8100, 2'b11);
    wait_resp(lat, mid_ss);
    chk("t7_mid_ss", {62'd0, mid_ss}, 64'h0);
    chk("t7_rdata", {48'd0, resp_rdata}, 64'hFF81);
    consume();
    chk("end_ready", {63'd0, req_ready}, 64'd1);
    chk("end_busy", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
